// File: rtl/resp_capture_serializer_pkg.sv
// Shared constants, FSM state type and signature step for the response
// capture serializer.
package resp_capture_serializer_pkg;

   localparam int unsigned WIDTH_DEF = 769;
   localparam int unsigned WORD      = 32;
   localparam logic [WORD-1:0] POLY  = 32'h04C11DB7;
   localparam logic [WORD-1:0] SEED  = 32'hFFFFFFFF;
   localparam int unsigned NW        = (WIDTH_DEF + WORD - 1) / WORD;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_DONE
   } state_e;

   function automatic logic [WORD-1:0] next_sig(input logic [WORD-1:0] s,
                                                input logic [WORD-1:0] w);
      return ({s[WORD-2:0], 1'b0} ^ (s[WORD-1] ? POLY : '0)) ^ w;
   endfunction

endpackage

// File: rtl/resp_capture_serializer_misr_step.sv
// One combinational signature step: shift left, fold POLY on the outgoing
// MSB, then absorb the word just sent.
module resp_misr_step
   import resp_capture_serializer_pkg::*;
#(
   parameter int unsigned      WORD = 32,
   parameter logic [WORD-1:0]  POLY = 32'h04C11DB7
) (
   input  logic [WORD-1:0] sig_in,
   input  logic [WORD-1:0] word_in,
   output logic [WORD-1:0] sig_out
);

   always_comb begin
      sig_out = ({sig_in[WORD-2:0], 1'b0} ^ (sig_in[WORD-1] ? POLY : '0)) ^ word_in;
   end

endmodule

// File: rtl/resp_capture_serializer.sv
// Captures a wide response vector, streams it out LSB word first with a
// ready/valid handshake, and reports a running signature at frame end.
module resp_capture_serializer #(
   parameter int unsigned      WIDTH = 769,
   parameter int unsigned      WORD  = 32,
   parameter logic [WORD-1:0]  POLY  = 32'h04C11DB7,
   parameter logic [WORD-1:0]  SEED  = 32'hFFFFFFFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cap_valid,
   output logic             cap_ready,
   input  logic [WIDTH-1:0] cap_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WORD-1:0]  out_data,
   output logic             out_last,
   output logic [4:0]       out_index,
   output logic [WORD-1:0]  sig,
   output logic             sig_valid
);

   import resp_capture_serializer_pkg::*;

   localparam int unsigned NW   = (WIDTH + WORD - 1) / WORD;
   localparam logic [4:0]  LAST = 5'(NW - 1);

   state_e                  state_q, state_d;
   logic [NW-1:0][WORD-1:0] data_q, data_d;
   logic [4:0]              idx_q, idx_d;
   logic [WORD-1:0]         sig_q, sig_d;
   logic [WORD-1:0]         word_sel;
   logic [WORD-1:0]         sig_next;

   always_comb begin
      word_sel = data_q[idx_q];
   end

   resp_misr_step #(
      .WORD (WORD),
      .POLY (POLY)
   ) u_misr (
      .sig_in  (sig_q),
      .word_in (word_sel),
      .sig_out (sig_next)
   );

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      idx_d     = idx_q;
      sig_d     = sig_q;
      cap_ready = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      sig_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cap_ready = 1'b1;
            if (cap_valid) begin
               // zero-extension keeps padding bits of the last word at 0
               data_d  = (NW*WORD)'(cap_data);
               idx_d   = '0;
               sig_d   = SEED;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            out_valid = 1'b1;
            out_data  = word_sel;
            out_last  = (idx_q == LAST);
            if (out_ready) begin
               sig_d = sig_next;
               if (idx_q == LAST) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         ST_DONE: begin
            sig_valid = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         sig_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sig_q   <= sig_d;
      end
   end

   // capture register needs no reset: it is only observable in SEND
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   always_comb begin
      out_index = idx_q;
      sig       = sig_q;
   end

endmodule
